sram_responder: RTL

//  Responder (memory) end of the SRAM-style en/we/addr/wdata/rdata interface that the CPU core drives for inst and data.

---
 rtl/sram_responder_pkg.sv | 15 +
 rtl/sram_responder_resp_fifo.sv | 65 ++++++
 rtl/sram_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared widths and the response
// entry layout used by the responder and its FIFO.
package sram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic              is_write;
        logic [WORD_W-1:0] rdata;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

endpackage

// File: rtl/sram_responder_resp_fifo.sv
// resp_fifo: synchronous response FIFO, head visible
// combinationally, asynchronous active-high reset.
module resp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // storage is not reset; only pointers and count define contents
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: word-addressed byte-enable RAM with fixed
// access latency and a bounded outstanding-request window.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [BE_W-1:0]   req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_is_write,
    output logic [WORD_W-1:0] resp_rdata,
    input  logic              resp_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NS    = LATENCY - 1;

    logic [WORD_W-1:0] mem [2**ADDR_W];

    logic [CNT_W-1:0]  out_cnt;
    logic              accept;
    logic              pop;
    logic [ADDR_W-1:0] req_idx;

    logic              acc_v;
    logic [BE_W-1:0]   acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [WORD_W-1:0] acc_wd;

    resp_t             push_ent;
    logic [RESP_W-1:0] head_raw;
    resp_t             head;
    logic              fifo_empty;
    logic              unused_full;
    logic              unused_addr;

    assign req_ready   = (out_cnt < CNT_W'(DEPTH));
    assign accept      = req_en && req_ready && !rst;
    assign pop         = resp_valid && resp_ready;
    assign req_idx     = req_addr[ADDR_W+1:2];
    assign unused_addr = ^{req_addr[1:0], req_addr[WORD_W-1:ADDR_W+2]};

    generate
        if (LATENCY == 1) begin : g_direct
            assign acc_v   = accept;
            assign acc_we  = req_we;
            assign acc_idx = req_idx;
            assign acc_wd  = req_wdata;
        end else begin : g_dly
            logic              dl_v   [NS];
            logic [BE_W-1:0]   dl_we  [NS];
            logic [ADDR_W-1:0] dl_idx [NS];
            logic [WORD_W-1:0] dl_wd  [NS];

            // stage valids: cleared on reset so in-flight writes are dropped
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_v <= '{default: 1'b0};
                end else begin
                    dl_v[0] <= accept;
                    for (int s = 1; s < NS; s++) begin
                        dl_v[s] <= dl_v[s-1];
                    end
                end
            end

            // stage payloads follow their valid bits
            always_ff @(posedge clk) begin
                dl_we[0]  <= req_we;
                dl_idx[0] <= req_idx;
                dl_wd[0]  <= req_wdata;
                for (int s = 1; s < NS; s++) begin
                    dl_we[s]  <= dl_we[s-1];
                    dl_idx[s] <= dl_idx[s-1];
                    dl_wd[s]  <= dl_wd[s-1];
                end
            end

            assign acc_v   = dl_v[NS-1];
            assign acc_we  = dl_we[NS-1];
            assign acc_idx = dl_idx[NS-1];
            assign acc_wd  = dl_wd[NS-1];
        end
    endgenerate

    // byte-merge write into the array when a write reaches it
    always_ff @(posedge clk) begin
        if (acc_v) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_we[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
                end
            end
        end
    end

    // response entry built from the access reaching the array
    always_comb begin
        push_ent.is_write = |acc_we;
        push_ent.rdata    = (|acc_we) ? '0 : mem[acc_idx];
    end

    // outstanding = delay line + FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (accept && !pop) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (pop && !accept) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

    resp_fifo #(
        .W     (RESP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (acc_v),
        .din   (push_ent),
        .pop   (pop),
        .empty (fifo_empty),
        .full  (unused_full),
        .head  (head_raw)
    );

    assign head          = resp_t'(head_raw);
    assign resp_valid    = !fifo_empty;
    assign resp_is_write = resp_valid && head.is_write;
    assign resp_rdata    = resp_valid ? head.rdata : '0;

endmodule
